// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// the sizing rule for its internal cycle counters.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Width wide enough to hold (largest terminal count - 1); never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer with synchronous clear; a plain shift chain
// so the tools see a clean CDC path.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbour; a blocking '=' here would collapse
  // the chain into a single stage.
  always_ff @(posedge clock) begin
    if (clear) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock into a filtered, synchronous active-high
// domain reset, with a ready flag and saturating lock-loss/glitch counters.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 65536,
  parameter int RESET_HOLD_CYCLES  = 256,
  parameter int GLITCH_CYCLES      = 4,
  parameter int CNT_W              = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             rst_out,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] glitch_count
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES, GLITCH_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 1);

  logic lock_s;

  sync_bit #(.N(SYNC_STAGES)) u_lock_sync (
    .clock (clock),
    .clear (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    gcnt_q, gcnt_d;
  logic             rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] glitch_q, glitch_d;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    loss_d   = loss_q;
    glitch_d = glitch_q;

    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d  = '0;
        gcnt_d = '0;
        if (lock_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // A low run shorter than GLITCH_CYCLES that ends high is a glitch.
        if (!lock_s) begin
          if (gcnt_q == GLITCH_LAST) begin
            state_d = WAIT_LOCK;
            gcnt_d  = '0;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end else if (gcnt_q != '0) begin
          gcnt_d = '0;
          if (glitch_q != '1) glitch_d = glitch_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      gcnt_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
      glitch_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gcnt_q    <= gcnt_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
      glitch_q  <= glitch_d;
    end
  end

  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_q;
  assign glitch_count    = glitch_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: run-length behavioural model checked every
// cycle, directed scenarios with literal expectations, then random lock noise.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LSC  = 16;
  localparam int RHC  = 8;
  localparam int GC   = 4;
  localparam int CW   = 2;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic          rst_out;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] lock_loss_count;
  logic [CW-1:0] glitch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC),
    .GLITCH_CYCLES     (GC),
    .CNT_W             (CW)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .rst_out        (rst_out),
    .ready          (ready),
    .state          (state),
    .lock_loss_count(lock_loss_count),
    .glitch_count   (glitch_count)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the domain is up once the FSM has observed 1+LSC+RHC consecutive
  // high synced-lock samples; it drops after GC consecutive low samples.
  bit [SYNC-1:0] hist;
  bit mvalid = 1'b0;
  bit in_run;
  int high_run, low_run, m_loss, m_glitch;

  always @(posedge clk) begin
    bit seen;
    if (reset) begin
      hist = '0; in_run = 0; high_run = 0; low_run = 0;
      m_loss = 0; m_glitch = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      seen = hist[SYNC-1];
      hist = {hist[SYNC-2:0], pll_locked};
      if (in_run) begin
        if (!seen) begin
          low_run++;
          if (low_run == GC) begin
            in_run = 0; high_run = 0; low_run = 0;
            if (m_loss < SAT) m_loss++;
          end
        end else begin
          if (low_run > 0 && m_glitch < SAT) m_glitch++;
          low_run = 0;
        end
      end else begin
        high_run = seen ? high_run + 1 : 0;
        if (high_run == 1 + LSC + RHC) begin
          in_run = 1; low_run = 0;
        end
      end
    end
  end

  function automatic int exp_state();
    if (in_run)            return 3;
    if (high_run == 0)     return 0;
    if (high_run <= LSC)   return 1;
    return 2;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_state",  int'(state),           exp_state());
      check("model_rst",    int'(rst_out),         in_run ? 0 : 1);
      check("model_ready",  int'(ready),           in_run ? 1 : 0);
      check("model_loss",   int'(lock_loss_count), m_loss);
      check("model_glitch", int'(glitch_count),    m_glitch);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_lock(input logic v);
    @(negedge clk);
    pll_locked = v;
  endtask

  // Raise lock and confirm release lands exactly on edge 27.
  task automatic relock_and_check(input string tag);
    drive_lock(1'b1);
    edges(26);
    check({tag, "_rst_e26"}, int'(rst_out), 1);
    edges(1);
    check({tag, "_rst_e27"}, int'(rst_out), 0);
    check({tag, "_ready_e27"}, int'(ready), 1);
    check({tag, "_state_e27"}, int'(state), 3);
  endtask

  task automatic lose_lock(input string tag, input int exp_loss);
    drive_lock(1'b0);
    edges(5);
    check({tag, "_rst_e5"}, int'(rst_out), 0);
    edges(1);
    check({tag, "_rst_e6"}, int'(rst_out), 1);
    check({tag, "_ready_e6"}, int'(ready), 0);
    check({tag, "_loss"}, int'(lock_loss_count), exp_loss);
  endtask

  initial begin
    reset = 1'b1;
    pll_locked = 1'b0;
    edges(3);
    check("reset_state", int'(state), 0);
    check("reset_rst", int'(rst_out), 1);
    check("reset_ready", int'(ready), 0);
    check("reset_loss", int'(lock_loss_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Clean lock
    relock_and_check("clean");

    // Glitch filter: 3 low samples in RUN
    drive_lock(1'b0);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    edges(8);
    check("glitch_rst", int'(rst_out), 0);
    check("glitch_count", int'(glitch_count), 1);
    check("glitch_loss", int'(lock_loss_count), 0);

    // Real loss, then full relock
    lose_lock("loss1", 1);
    edges(4);
    relock_and_check("relock1");

    // Early drop during WAIT/STABILIZE
    lose_lock("loss2", 2);
    edges(3);
    drive_lock(1'b1);
    repeat (9) @(negedge clk);
    pll_locked = 1'b0;
    edges(4);
    check("early_state", int'(state), 0);
    relock_and_check("early");
    check("early_loss", int'(lock_loss_count), 2);
    check("early_glitch", int'(glitch_count), 1);

    // Saturation: three more losses push the 2-bit counter to its cap
    lose_lock("loss3", 3);
    relock_and_check("relock3");
    lose_lock("loss4", 3);
    relock_and_check("relock4");
    lose_lock("loss5", 3);

    // Reset while in HOLD
    drive_lock(1'b1);
    edges(22);
    check("hold_state", int'(state), 2);
    @(negedge clk);
    reset = 1'b1;
    edges(1);
    check("hold_reset_state", int'(state), 0);
    check("hold_reset_rst", int'(rst_out), 1);
    check("hold_reset_loss", int'(lock_loss_count), 0);
    check("hold_reset_glitch", int'(glitch_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Random lock noise with occasional external reset
    for (int seg = 0; seg < 150; seg++) begin
      int hi_len, lo_len;
      hi_len = $urandom_range(1, 60);
      lo_len = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 8) : $urandom_range(1, 4);
      repeat (hi_len) begin
        @(negedge clk);
        pll_locked = 1'b1;
        reset = ($urandom_range(0, 199) == 0);
      end
      repeat (lo_len) begin
        @(negedge clk);
        pll_locked = 1'b0;
        reset = 1'b0;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    edges(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
